// File: rtl/bin2bcd_iter_if.sv
// Handshake bundle for the iterative binary-to-BCD converter.
// The master supplies operands and accepts results; the slave is the converter.
interface bin2bcd_iter_if #(
   parameter int BIN_W      = 16,
   parameter int BCD_DIGITS = 5
);
   logic                    in_valid;
   logic                    in_ready;
   logic [BIN_W-1:0]        bin_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [4*BCD_DIGITS-1:0] bcd_out;
   logic                    sign_out;

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, sign_out
   );

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, sign_out
   );
endinterface

// File: rtl/bin2bcd_iter.sv
// Serial double-dabble binary-to-BCD converter: one operand per handshake,
// BIN_W shift cycles per conversion, optional two's-complement sign/magnitude.
module bin2bcd_iter #(
   parameter int BIN_W      = 16,
   parameter int BCD_DIGITS = 5,
   parameter int SIGNED     = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   bin2bcd_iter_if.slave bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * BCD_DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             in_ready;
   logic             out_valid;
   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] bcd_acc;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         if (r < 64'd1000000000000000000) r = r * 64'd10;
      end
      return r;
   endfunction

   if (BIN_W < 2 || BIN_W > 32) begin : g_bad_width
      $error("bin2bcd_iter: BIN_W=%0d outside 2..32", BIN_W);
   end
   if (pow10(BCD_DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
      $error("bin2bcd_iter: %0d digits cannot hold a %0d-bit value", BCD_DIGITS, BIN_W);
   end

   function automatic logic is_neg(input logic [BIN_W-1:0] b);
      return (SIGNED != 0) && b[BIN_W-1];
   endfunction

   // Most negative input wraps to 2^(BIN_W-1), which is the correct magnitude.
   function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] b);
      if (is_neg(b)) return ~b + BIN_W'(1);
      return b;
   endfunction

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
      logic [BCD_W-1:0] r;
      r = d;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  load      = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator doubles as the result register: it is frozen while in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr  <= '0;
         bcd_acc <= '0;
         cnt     <= '0;
         sign_q  <= 1'b0;
      end else if (load) begin
         bin_sr  <= magnitude(bus.bin_in);
         bcd_acc <= '0;
         cnt     <= CNT_W'(BIN_W);
         sign_q  <= is_neg(bus.bin_in);
      end else if (state == SHIFT) begin
         {bcd_acc, bin_sr} <= {add3(bcd_acc), bin_sr} << 1;
         cnt               <= cnt - CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.bcd_out   = bcd_acc;
   assign bus.sign_out  = sign_q;
endmodule

// File: doc/bin2bcd_iter.md
# bin2bcd_iter

Parametrised, iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes one W-bit binary word per transaction over a valid/ready handshake, converts it serially in W clock cycles, and returns packed BCD digits over a second valid/ready handshake. Optional two's-complement input handling produces sign + magnitude. It sits between datapath logic and display/UART formatting logic in the bin2bcd subsystem.

## Interface
- BIN_W, 16: input binary width, 2..32.
- BCD_DIGITS, 5: output digit count; must satisfy 10^BCD_DIGITS > 2^BIN_W - 1. An illegal combination is a configuration error, flagged by an elaboration-time check.
- SIGNED, 0: 0 treats the input as unsigned; 1 treats it as two's complement and converts its magnitude.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  converter can accept; a transfer occurs when in_valid & in_ready are high at a rising edge.
- bin_in  input  BIN_W  binary operand.
- out_valid  output  1  bcd_out/sign_out hold a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*BCD_DIGITS  packed BCD; digit 0 (units) in [3:0].
- sign_out  output  1  1 = negative input (SIGNED=1 only; tied 0 when SIGNED=0).

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - On a transfer, load the shift register with the magnitude of bin_in, clear the BCD accumulator, load the bit counter with BIN_W, capture the sign, and go to SHIFT.
- **SHIFT**
  - in_ready=0, out_valid=0.
  - Each cycle, add 3 to every BCD digit ≥5, then shift {bcd, bin} left by 1 and decrement the counter.
  - After the BIN_W-th shift (counter reaches 0), go to DONE.
- **DONE**
  - out_valid=1.
  - bcd_out and sign_out are registered and held stable until accepted.
  - On out_ready:
    - if in_valid is also high, accept the new operand in the same cycle and go to SHIFT;
    - otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready.
- Magnitude (SIGNED=1): if bin_in[BIN_W-1]=1, the magnitude is (~bin_in + 1) taken as BIN_W-bit unsigned. The most negative value 2^(BIN_W-1) is therefore converted correctly with sign_out=1. Zero always gives sign_out=0.
- Add-3 correction uses 4-bit arithmetic per digit; no carry crosses digits.
- The counter is $clog2(BIN_W+1) bits wide.
- in_valid is ignored outside states where in_ready=1. bin_in is sampled only on the transfer edge and may change afterwards.

## Timing
- Reset, asserted asynchronously at any time including mid-conversion:
  - state=IDLE, out_valid=0, bcd_out=0, sign_out=0;
  - internal shift and counter registers cleared;
  - in_ready=1 once state is IDLE;
  - any in-flight conversion is discarded and no result is produced.
- Latency:
  - transfer at edge E0;
  - shifts at E1..E(BIN_W);
  - out_valid is high from E(BIN_W) onward.
- out_valid falls at the edge where out_valid & out_ready, unless a new operand is accepted at that edge (then it falls and a new conversion starts).
- Throughput: one result per BIN_W+1 cycles with out_ready held high and in_valid continuously high.
- Backpressure: with out_ready low, DONE is held indefinitely, the outputs do not change, and in_ready=0.

## Test plan
- Unsigned, BIN_W=16, BCD_DIGITS=5: 0 → bcd_out=0x00000; 12345 → 0x12345; 65535 → 0x65535. In each case out_valid rises exactly 16 edges after the transfer.
- SIGNED=1, BIN_W=8, BCD_DIGITS=3:
  - 0x80 → sign_out=1, bcd_out=0x128;
  - 0xFF → sign_out=1, bcd_out=0x001;
  - 0x7F → sign_out=0, bcd_out=0x127;
  - 0x00 → sign_out=0, bcd_out=0x000.
- Backpressure: complete a conversion of 999, hold out_ready=0 for 10 cycles → out_valid stays 1, bcd_out stays 0x00999, in_ready stays 0. Raise out_ready → a single handshake, then IDLE.
- Back-to-back: in_valid and out_ready held high with a stream of 1, 2, 3 → results 0x00001, 0x00002, 0x00003 with out_valid pulses spaced 17 cycles apart. Each new operand is accepted on the same edge as the previous result's acceptance.
- Reset mid-conversion: assert rst_n=0 at shift 7 of a conversion of 40000 → outputs immediately 0 and state IDLE. After release, convert 42 → 0x00042 with normal latency and no stale out_valid.
- Random sweep: 1000 random unsigned operands with random in_valid/out_ready gaps → every bcd_out matches a reference decimal conversion, every digit ≤9, and no transaction is lost or duplicated.
